// File: rtl/system_rst_seq.sv
// system_rst_seq: holds PLLs in reset, waits for stable lock, then releases domain resets in order.
// Optional RST_SEQ_LOSS_CNT_EN adds loss_cnt (RUN lock-loss count) and loss_ch (first-loss channel mask).
module system_rst_seq #(
   parameter int NUM_CH       = 3,
   parameter int PLL_RST_CYC  = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 1000000,
   parameter int CH_GAP       = 256,
   parameter int MAX_RETRY    = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              pll_locked,
   output logic                           pll_rst,
   output logic [NUM_CH-1:0]              ch_rst_n,
   output logic                           sys_ready,
   output logic                           fault,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
`ifdef RST_SEQ_LOSS_CNT_EN
   output logic [7:0]                     loss_cnt,
   output logic [NUM_CH-1:0]              loss_ch,
`endif
   output logic [2:0]                     seq_state
);

   localparam int RW     = $clog2(MAX_RETRY + 1);
   localparam int CMAX_A = (PLL_RST_CYC > CH_GAP) ? PLL_RST_CYC : CH_GAP;
   localparam int CMAX   = (LOCK_TIMEOUT > CMAX_A) ? LOCK_TIMEOUT : CMAX_A;
   localparam int CW     = $clog2(CMAX);
   localparam int SW     = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
   localparam int KW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [SW-1:0]     scnt, scnt_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [RW-1:0]     retry_nxt, retry_inc;
   logic [NUM_CH-1:0] sync1, lk;
   logic              all_lk, failed;
   logic              pll_rst_nxt, sys_ready_nxt, fault_nxt;
   logic [NUM_CH-1:0] ch_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         lk    <= '0;
      end else begin
         sync1 <= pll_locked;
         lk    <= sync1;
      end
   end

   assign all_lk = &lk;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         cnt       <= '0;
         scnt      <= '0;
         k         <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         ch_rst_n  <= '0;
         sys_ready <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         scnt      <= scnt_nxt;
         k         <= k_nxt;
         retry_cnt <= retry_nxt;
         pll_rst   <= pll_rst_nxt;
         ch_rst_n  <= ch_nxt;
         sys_ready <= sys_ready_nxt;
         fault     <= fault_nxt;
      end
   end

   // One counter is shared by INIT hold, WAIT_LOCK timeout and RELEASE gap; it is cleared on every entry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      scnt_nxt  = '0;
      k_nxt     = k;
      retry_nxt = retry_cnt;
      failed    = 1'b0;
      retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
      case (state)
         ST_INIT: begin
            if (cnt == CW'(PLL_RST_CYC - 1)) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            scnt_nxt = all_lk ? scnt + 1'b1 : '0;
            if (all_lk && scnt == SW'(LOCK_STABLE - 1)) begin
               state_nxt = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
               cnt_nxt   = '0;
               scnt_nxt  = '0;
               k_nxt     = '0;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               failed = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!all_lk) begin
               failed = 1'b1;
            end else if (cnt == CW'(CH_GAP - 1)) begin
               cnt_nxt = '0;
               k_nxt   = k + 1'b1;
               if (k == KW'(NUM_CH - 2)) state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_nxt = cnt;
            if (!all_lk) begin
               retry_nxt = retry_inc;
               state_nxt = ST_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            cnt_nxt = cnt;
         end
      endcase
      if (failed) begin
         retry_nxt = retry_inc;
         state_nxt = (retry_inc >= RW'(MAX_RETRY)) ? ST_FAULT : ST_INIT;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      pll_rst_nxt   = (state_nxt == ST_INIT) || (state_nxt == ST_FAULT);
      sys_ready_nxt = (state_nxt == ST_RUN);
      fault_nxt     = (state_nxt == ST_FAULT);
      ch_nxt        = '0;
      if (state_nxt == ST_RELEASE || state_nxt == ST_RUN) begin
         for (int unsigned i = 0; i < NUM_CH; i++) ch_nxt[i] = (i <= 32'(k_nxt));
      end
   end

   assign seq_state = state;

`ifdef RST_SEQ_LOSS_CNT_EN
   logic run_loss;
   assign run_loss = (state == ST_RUN) && !all_lk;

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_cnt <= '0;
         loss_ch  <= '0;
      end else if (run_loss) begin
         if (loss_cnt == 8'd0)  loss_ch  <= ~lk;
         if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
      end
   end
`endif

endmodule
